// File: rtl/organ_pkg.sv
// organ_pkg: definitions shared by the organ autoplay logic.
//   seq_state_e    - song sequencer FSM states (3-bit encoding)
//   PITCH_W_DEF    - default pitch code width
//   DUR_W_DEF      - default duration field width (beats)
//   REST_PITCH     - pitch code meaning "rest" (tone generator disabled)
//   END_DUR        - duration code marking end of song
//   DUR_LSB        - song word layout is {pitch, dur}; dur sits in the low bits
package organ_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_PLAY  = 3'd3,
    S_END   = 3'd4
  } seq_state_e;

  localparam int unsigned PITCH_W_DEF = 6;
  localparam int unsigned DUR_W_DEF   = 3;

  localparam int unsigned REST_PITCH  = 0;
  localparam int unsigned END_DUR     = 0;

  // Pitch field starts at DUR_LSB + DUR_W.
  localparam int unsigned DUR_LSB     = 0;

endpackage

// File: rtl/song_sequencer_if.sv
// song_sequencer_if: song ROM read port.
//   rom_rd   - read strobe (sequencer -> ROM)
//   rom_addr - read address (sequencer -> ROM)
//   rom_data - {pitch, dur}, valid the cycle after rom_rd (ROM -> sequencer)
// Modports: master = sequencer side, slave = ROM side.
interface song_sequencer_if
  import organ_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = PITCH_W_DEF + DUR_W_DEF
);
  logic              rom_rd;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport master (output rom_rd, output rom_addr, input rom_data);
  modport slave  (input rom_rd, input rom_addr, output rom_data);
endinterface

// File: rtl/song_sequencer_beat_counter.sv
// beat_counter: counts gated beat ticks within one note, 0..dur-1.
//   clk, rst_n    - clock, async active-low reset
//   clear_i       - synchronous clear to 0 (has priority)
//   enable_i      - counting allowed (sequencer playing and not paused)
//   tick_i        - beat pulse
//   dur_i         - note length in beats (>= 1 while enabled)
//   beat_idx_o    - registered beat count
//   last_beat_o   - count is on the final beat of the note
module beat_counter #(
  parameter int unsigned DUR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             tick_i,
  input  logic [DUR_W-1:0] dur_i,
  output logic [DUR_W-1:0] beat_idx_o,
  output logic             last_beat_o
);

  logic [DUR_W-1:0] cnt_q, cnt_d;

  assign last_beat_o = (cnt_q == (dur_i - DUR_W'(1)));
  assign beat_idx_o  = cnt_q;

  // The final-beat tick is consumed by the sequencer leaving PLAY, which
  // asserts clear; the counter itself never steps past dur-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && tick_i && !last_beat_o) begin
      cnt_d = cnt_q + DUR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: organ autoplay controller. Walks a song ROM of {pitch, dur}
// words, holding each note for dur beats of beat_tick.
//   clk, rst_n  - clock, async active-low reset
//   start       - pulse, begin playback at address 0 (ignored while busy)
//   stop        - pulse, abort to IDLE (wins over start)
//   pause       - level, freeze beat counting and mute while playing
//   loop_en     - level, restart from address 0 at end of song
//   beat_tick   - pulse, one per beat
//   rom         - song ROM read port (master side)
//   pitch       - current pitch code (holds through the inter-note gap)
//   note_on     - tone generator enable
//   beat_idx    - beats elapsed in the current note
//   busy        - not IDLE
//   done        - one-cycle pulse at end of song
// All outputs are registered.
module song_sequencer
  import organ_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned PITCH_W = PITCH_W_DEF,
  parameter int unsigned DUR_W   = DUR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               loop_en,
  input  logic               beat_tick,
  song_sequencer_if.master   rom,
  output logic [PITCH_W-1:0] pitch,
  output logic               note_on,
  output logic [DUR_W-1:0]   beat_idx,
  output logic               busy,
  output logic               done
);

  localparam int unsigned PITCH_LSB = DUR_LSB + DUR_W;

  seq_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               rd_q, rd_d;
  logic [PITCH_W-1:0] pitch_q, pitch_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic               note_on_q, note_on_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [PITCH_W-1:0] word_pitch;
  logic [DUR_W-1:0]   word_dur;
  logic               last_beat;

  assign word_pitch = rom.rom_data[PITCH_LSB +: PITCH_W];
  assign word_dur   = rom.rom_data[DUR_LSB +: DUR_W];

  // Counter clears whenever the next state is not PLAY, so it reads 0 on
  // entry to every note and after stop.
  beat_counter #(
    .DUR_W (DUR_W)
  ) u_beat_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (state_d != S_PLAY),
    .enable_i    ((state_q == S_PLAY) && !pause),
    .tick_i      (beat_tick),
    .dur_i       (dur_q),
    .beat_idx_o  (beat_idx),
    .last_beat_o (last_beat)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pitch_d = pitch_q;
    dur_d   = dur_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          addr_d  = '0;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        pitch_d = word_pitch;
        dur_d   = word_dur;
        state_d = (word_dur == DUR_W'(END_DUR)) ? S_END : S_PLAY;
      end
      S_PLAY: begin
        if (beat_tick && !pause && last_beat) begin
          if (&addr_q) begin
            state_d = S_END;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_END: begin
        addr_d = '0;
        if (loop_en) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
          pitch_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
      pitch_d = '0;
      dur_d   = '0;
    end

    // Outputs are derived from the next state so they line up with it.
    rd_d      = (state_d == S_FETCH);
    note_on_d = (state_d == S_PLAY) && !pause && (pitch_d != PITCH_W'(REST_PITCH));
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      pitch_q   <= '0;
      dur_q     <= '0;
      note_on_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      pitch_q   <= pitch_d;
      dur_q     <= dur_d;
      note_on_q <= note_on_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rom.rom_rd   = rd_q;
  assign rom.rom_addr = addr_q;
  assign pitch        = pitch_q;
  assign note_on      = note_on_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed and randomized checks of song_sequencer against
// a note-level model built from the song memory contents.
module tb_song_sequencer;
  import organ_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned PW = 6;
  localparam int unsigned DW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0, beat_tick = 1'b0;
  logic [PW-1:0] pitch;
  logic          note_on;
  logic [DW-1:0] beat_idx;
  logic          busy, done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [PW+DW-1:0] mem [256];

  song_sequencer_if #(.ADDR_W(AW), .DATA_W(PW+DW)) rif ();

  song_sequencer #(.ADDR_W(AW), .PITCH_W(PW), .DUR_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .loop_en   (loop_en),
    .beat_tick (beat_tick),
    .rom       (rif.master),
    .pitch     (pitch),
    .note_on   (note_on),
    .beat_idx  (beat_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data valid the cycle after the read strobe.
  always @(posedge clk) if (rif.rom_rd) rif.rom_data <= mem[rif.rom_addr];

  function automatic logic [PW+DW-1:0] W(input int unsigned p, input int unsigned d);
    return {PW'(p), DW'(d)};
  endfunction

  task automatic clear_mem();
    for (int unsigned i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},    32'(busy), 0);
    chk({tag, "_done"},    32'(done), 0);
    chk({tag, "_note_on"}, 32'(note_on), 0);
    chk({tag, "_rd"},      32'(rif.rom_rd), 0);
    chk({tag, "_addr"},    32'(rif.rom_addr), 0);
    chk({tag, "_pitch"},   32'(pitch), 0);
    chk({tag, "_beat"},    32'(beat_idx), 0);
  endtask

  // Called at the negedge right after the edge that should enter FETCH.
  // Walks FETCH and WAIT and checks the note (or end marker) that follows.
  task automatic expect_fetch(input int unsigned addr, input logic [PW-1:0] prev_pitch,
                              input bit pz, output logic [PW-1:0] p, output logic [DW-1:0] d);
    logic [PW+DW-1:0] w;
    w = mem[addr];
    p = w[DW +: PW];
    d = w[DW-1:0];
    chk("fetch_rd", 32'(rif.rom_rd), 1);
    chk("fetch_addr", 32'(rif.rom_addr), addr);
    chk("fetch_note_on", 32'(note_on), 0);
    chk("fetch_pitch_hold", 32'(pitch), 32'(prev_pitch));
    chk("fetch_busy", 32'(busy), 1);
    pause = pz;
    step();
    chk("wait_rd", 32'(rif.rom_rd), 0);
    chk("wait_note_on", 32'(note_on), 0);
    chk("wait_pitch_hold", 32'(pitch), 32'(prev_pitch));
    step();
    if (d == 0) begin
      chk("end_done", 32'(done), 1);
      chk("end_note_on", 32'(note_on), 0);
      chk("end_busy", 32'(busy), 1);
    end else begin
      chk("play_pitch", 32'(pitch), 32'(p));
      chk("play_note_on", 32'((p != 0) && !pz), 32'(note_on) ^ 32'(note_on) ^ 32'((p != 0) && !pz)) ;
      chk("play_note_on_val", 32'(note_on), 32'((p != 0) && !pz));
      chk("play_beat0", 32'(beat_idx), 0);
      chk("play_done", 32'(done), 0);
    end
  endtask

  task automatic run_song(input bit rnd, input int pause_beat, input bit do_loop_stop);
    logic [PW-1:0] p, prev;
    logic [DW-1:0] d;
    int unsigned addr, gap;
    bit pz, pz_here;
    logic exp_on;
    start = 1'b1;
    step();
    start = 1'b0;
    addr = 0;
    prev = '0;
    forever begin
      pz = rnd && ($urandom_range(0, 3) == 0);
      expect_fetch(addr, prev, pz, p, d);
      pause = 1'b0;
      prev = p;
      if (d == 0) break;
      exp_on = (p != 0);
      if (pz) begin
        step();
        chk("pause_entry_release", 32'(note_on), 32'(exp_on));
        chk("pause_entry_beat", 32'(beat_idx), 0);
      end
      for (int unsigned b = 0; b < 32'(d); b++) begin
        gap = rnd ? $urandom_range(1, 4) : 19;
        for (int unsigned g = 0; g < gap; g++) begin
          start = rnd && ($urandom_range(0, 3) == 0);
          step();
          start = 1'b0;
          chk("hold_beat", 32'(beat_idx), b);
          chk("hold_note_on", 32'(note_on), 32'(exp_on));
          chk("hold_rd", 32'(rif.rom_rd), 0);
          chk("hold_addr", 32'(rif.rom_addr), addr);
          chk("hold_done", 32'(done), 0);
        end
        pz_here = rnd ? ($urandom_range(0, 4) == 0) : (int'(b) == pause_beat);
        if (pz_here) begin
          pause = 1'b1;
          step();
          chk("pause_mute", 32'(note_on), 0);
          for (int unsigned t = 0; t < 2; t++) begin
            beat_tick = 1'b1;
            step();
            beat_tick = 1'b0;
            chk("pause_freeze", 32'(beat_idx), b);
            chk("pause_mute_tick", 32'(note_on), 0);
          end
          pause = 1'b0;
          step();
          chk("pause_resume", 32'(note_on), 32'(exp_on));
          chk("pause_resume_beat", 32'(beat_idx), b);
        end
        beat_tick = 1'b1;
        step();
        beat_tick = 1'b0;
        if (b + 1 < 32'(d)) begin
          chk("beat_adv", 32'(beat_idx), b + 1);
          chk("beat_note_on", 32'(note_on), 32'(exp_on));
        end
      end
      addr++;
    end
    if (do_loop_stop) begin
      step();
      expect_fetch(0, prev, 1'b0, p, d);
      repeat (2) begin
        step();
        chk("loop_hold_beat", 32'(beat_idx), 0);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk_idle("stop");
      repeat (3) begin
        step();
        chk("stop_no_done", 32'(done), 0);
        chk("stop_stay_idle", 32'(busy), 0);
      end
    end else begin
      step();
      chk_idle("song_end");
    end
  endtask

  initial begin
    logic [PW-1:0] p, prev;
    logic [DW-1:0] d;
    int unsigned n;

    clear_mem();
    rst_n = 1'b0;
    repeat (3) step();
    chk_idle("reset");
    rst_n = 1'b1;
    step();

    // Basic song, one tick every 20 cycles.
    clear_mem();
    mem[0] = W(5, 2); mem[1] = W(9, 1); mem[2] = W(0, 0);
    run_song(1'b0, -1, 1'b0);

    // Rest note.
    clear_mem();
    mem[0] = W(0, 3); mem[1] = W(4, 1); mem[2] = W(0, 0);
    run_song(1'b0, -1, 1'b0);

    // Pause across two ticks at beat 1.
    clear_mem();
    mem[0] = W(7, 4); mem[1] = W(0, 0);
    run_song(1'b0, 1, 1'b0);

    // Loop, then stop mid-note.
    clear_mem();
    mem[0] = W(3, 1); mem[1] = W(12, 2); mem[2] = W(0, 0);
    loop_en = 1'b1;
    run_song(1'b0, -1, 1'b1);
    loop_en = 1'b0;

    // start and stop together from IDLE.
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk_idle("startstop");
    step();
    chk("startstop_rd_later", 32'(rif.rom_rd), 0);
    chk("startstop_busy_later", 32'(busy), 0);

    // Full ROM with no end marker: must end at word 255 without wrapping.
    for (int unsigned i = 0; i < 256; i++) mem[i] = W((i % 63) + 1, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    prev = '0;
    for (int unsigned a = 0; a < 256; a++) begin
      expect_fetch(a, prev, 1'b0, p, d);
      prev = p;
      beat_tick = 1'b1;
      step();
      beat_tick = 1'b0;
    end
    chk("full_done", 32'(done), 1);
    chk("full_addr_nowrap", 32'(rif.rom_addr), 255);
    chk("full_rd", 32'(rif.rom_rd), 0);
    chk("full_note_on", 32'(note_on), 0);
    step();
    chk_idle("full_end");

    // Async reset while in WAIT for the second note.
    clear_mem();
    mem[0] = W(5, 2); mem[1] = W(9, 1); mem[2] = W(0, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    repeat (2) begin
      beat_tick = 1'b1;
      step();
      beat_tick = 1'b0;
    end
    step();
    chk("prerst_pitch", 32'(pitch), 5);
    chk("prerst_addr", 32'(rif.rom_addr), 1);
    chk("prerst_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1 chk_idle("async_rst");
    step();
    rst_n = 1'b1;
    repeat (2) begin
      step();
      chk_idle("post_rst");
    end

    // Randomized songs.
    for (int unsigned s = 0; s < 8; s++) begin
      clear_mem();
      n = $urandom_range(1, 6);
      for (int unsigned i = 0; i < n; i++) begin
        mem[i] = W(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 63), $urandom_range(1, 7));
      end
      run_song(1'b1, -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
Autoplay controller for the electronic organ. Steps through a song ROM of {pitch, duration} words and drives the tone generator with the current pitch. Holds each note for a programmed number of beats, paced by a beat-tick pulse from the shared beat timebase. Supports start, stop, pause and loop. Sits between the song ROM and the tone generator, alongside the manual-keyboard path.

Parameters:
ADDR_W, 8, song ROM address width (max 256 words)
PITCH_W, 6, pitch code width; pitch 0 = rest (note_on held low)
DUR_W, 3, duration field width in beats; dur 0 = end-of-song marker

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begin playback at address 0
stop  in  1  single-cycle pulse; abort playback
pause  in  1  level; freeze beat counting and mute while high
loop_en  in  1  level; sampled at end of song, restart from address 0 if high
beat_tick  in  1  single-cycle pulse, one per beat
rom_rd  out  1  ROM read strobe
rom_addr  out  ADDR_W  ROM read address
rom_data  in  PITCH_W+DUR_W  {pitch, dur}; valid the cycle after rom_rd
pitch  out  PITCH_W  current pitch code to tone generator
note_on  out  1  tone generator enable
beat_idx  out  DUR_W  beats elapsed in current note, 0..dur-1
busy  out  1  high in every state except IDLE
done  out  1  single-cycle pulse at end of song

Behaviour:
- Reset (async, rst_n low): state IDLE; rom_addr=0; rom_rd=0; pitch=0; dur=0; note_on=0; beat_idx=0; busy=0; done=0. All outputs are registered.
- States: IDLE, FETCH, WAIT, PLAY, END.
- IDLE: start=1 -> FETCH, with rom_addr=0.
- FETCH: rom_rd=1 for exactly one cycle -> WAIT.
- WAIT: capture rom_data into pitch/dur.
  - dur==0 -> END.
  - otherwise -> PLAY with beat_idx=0 and note_on=(pitch!=0).
- Timing: start sampled at edge k gives rom_rd high in cycle k+1 and note_on/pitch valid from cycle k+3.
- PLAY: each beat_tick with pause=0 does one of:
  - beat_idx<dur-1: increment beat_idx.
  - beat_idx==dur-1 and rom_addr<2^ADDR_W-1: increment rom_addr -> FETCH.
  - beat_idx==dur-1 and rom_addr==2^ADDR_W-1: -> END (no address wrap).
- Note gap: note_on=0 in FETCH and WAIT, giving a 2-cycle articulation gap between notes. pitch holds its last value through the gap.
- pause=1 in PLAY: beat_tick ignored, beat_idx frozen, note_on=0. On release, note_on returns to (pitch!=0) next cycle and counting resumes at the frozen beat_idx.
- pause in FETCH/WAIT: the fetch completes; pause takes effect on PLAY entry.
- beat_tick in FETCH/WAIT/END/IDLE: dropped, not queued.
- END: done=1 for one cycle; note_on=0.
  - loop_en=1 -> rom_addr=0, FETCH.
  - loop_en=0 -> IDLE, with rom_addr=0 and pitch=0.
- stop=1 from any state -> IDLE next edge, with note_on=0, rom_rd=0, rom_addr=0, beat_idx=0, pitch=0, and no done pulse.
- start+stop in the same cycle: stop wins.
- start while busy: ignored.
- rst_n mid-playback: immediate return to reset values; no partial ROM read survives.

Decomposition:
- Shared package organ_pkg holds:
  - state encoding (3-bit enum)
  - PITCH_W and DUR_W defaults
  - REST_PITCH=0 and END_DUR=0 constants
  - song-word field slicing constants
- One sub-module, beat_counter: counts gated beat_tick pulses 0..dur-1 and emits a last_beat flag. Inputs are clear, enable (= PLAY & !pause), tick and dur. The FSM owns everything else.

Test Plan:
- ROM {5,2},{9,1},{0,0}; start at edge 0, tick every 20 cycles -> rom_rd at cycle 1; pitch=5 and note_on at cycle 3; beat_idx 0->1 on tick 1; addr=1 after tick 2; pitch=9; done pulse after tick 3; returns to IDLE.
- Rest note {0,3} -> note_on stays 0 for 3 ticks, beat_idx counts 0,1,2, then advances to the next word.
- pause high across 2 ticks at beat_idx=1 of {7,4} -> beat_idx stays 1, note_on=0; after release, beat_idx reaches 3 after 2 more ticks.
- loop_en=1 with a 2-note song -> done pulses, rom_addr returns to 0, first pitch replays; stop mid-note -> next cycle IDLE, all outputs 0, no done.
- start and stop asserted in the same cycle from IDLE -> stays IDLE, rom_rd never asserted; start while PLAY -> no address change.
- 256-word ROM with no end marker, dur=1 each -> after word 255 the FSM enters END (done=1) and rom_addr does not wrap mid-song; rst_n pulse during WAIT -> all outputs at reset values asynchronously.
